// File: rtl/dcache_pkg.sv
// Shared types and constants for the dCache-to-AXI4 bridge.
package dcache_pkg;

  localparam int DCACHE_B          = 5;
  localparam int DCACHE_LINE_WORDS = 2 ** (DCACHE_B - 2);

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} bridge_state_t;

endpackage

// File: rtl/dcache_axi_bridge.sv
// Turns dCache line refills / writebacks into single AXI4 INCR bursts, one at a time.
// Optional DCACHE_AXI_RESP_CHK_EN adds rresp/bresp inputs and a sticky bus_err output.
module dcache_axi_bridge
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = DCACHE_LINE_WORDS,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             addr_ok,
  output logic             data_ok,
  output logic [31:0]      rdata,
  output logic [IDX_W-1:0] w_idx,
  output logic             done,
  output logic [31:0]      araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata_axi,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      awaddr,
  output logic [7:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      wdata_axi,
  output logic [3:0]       wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  input  logic             bvalid,
`ifdef DCACHE_AXI_RESP_CHK_EN
  input  logic [1:0]       rresp,
  input  logic [1:0]       bresp,
  output logic             bus_err,
`endif
  output logic             bready
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LINE_WORDS - 1);
  localparam logic [31:0]      ALIGN_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  bridge_state_t    state, state_d;
  logic [IDX_W-1:0] r_cnt, r_cnt_d, w_idx_d;
  logic [31:0]      araddr_d, awaddr_d, rdata_d;
  logic             addr_ok_d, data_ok_d, done_d;
  logic             arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
`ifdef DCACHE_AXI_RESP_CHK_EN
  logic             bus_err_d;
`endif

  assign arlen     = 8'(LINE_WORDS - 1);
  assign awlen     = 8'(LINE_WORDS - 1);
  assign arsize    = AXI_SIZE_4B;
  assign awsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign awburst   = AXI_BURST_INCR;
  assign wstrb     = 4'hF;
  assign wdata_axi = wdata;
  assign wlast     = (w_idx == LAST_IDX);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state;
    araddr_d  = araddr;
    awaddr_d  = awaddr;
    rdata_d   = rdata;
    r_cnt_d   = r_cnt;
    w_idx_d   = w_idx;
    arvalid_d = arvalid;
    rready_d  = rready;
    awvalid_d = awvalid;
    wvalid_d  = wvalid;
    bready_d  = bready;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    done_d    = 1'b0;
`ifdef DCACHE_AXI_RESP_CHK_EN
    bus_err_d = bus_err;
`endif
    unique case (state)
      IDLE: begin
        // The done cycle is skipped so a held req re-enters only after a one-cycle gap.
        if (req && !done) begin
          addr_ok_d = 1'b1;
          araddr_d  = addr & ALIGN_MASK;
          awaddr_d  = addr & ALIGN_MASK;
          if (wr) begin
            awvalid_d = 1'b1;
            w_idx_d   = '0;
            state_d   = AW;
          end else begin
            arvalid_d = 1'b1;
            r_cnt_d   = '0;
            state_d   = AR;
          end
        end
      end
      AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid) begin
          rdata_d   = rdata_axi;
          data_ok_d = 1'b1;
          r_cnt_d   = r_cnt + 1'b1;
`ifdef DCACHE_AXI_RESP_CHK_EN
          if (rresp != AXI_RESP_OKAY || (rlast && r_cnt != LAST_IDX)) bus_err_d = 1'b1;
`endif
          // Only rlast ends the burst; the counter simply wraps if the slave overruns.
          if (rlast) begin
            rready_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      AW: begin
        if (awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          state_d   = W;
        end
      end
      W: begin
        if (wready) begin
          w_idx_d   = w_idx + 1'b1;
          data_ok_d = 1'b1;
          if (wlast) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = B;
          end
        end
      end
      B: begin
        if (bvalid) begin
`ifdef DCACHE_AXI_RESP_CHK_EN
          if (bresp != AXI_RESP_OKAY) bus_err_d = 1'b1;
`endif
          bready_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here is reset, since the interconnect is reset alongside and
  // any stale valid/ready left behind would be seen as a live handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      araddr  <= '0;
      awaddr  <= '0;
      rdata   <= '0;
      r_cnt   <= '0;
      w_idx   <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      addr_ok <= 1'b0;
      data_ok <= 1'b0;
      done    <= 1'b0;
`ifdef DCACHE_AXI_RESP_CHK_EN
      bus_err <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state   <= state_d;
      araddr  <= araddr_d;
      awaddr  <= awaddr_d;
      rdata   <= rdata_d;
      r_cnt   <= r_cnt_d;
      w_idx   <= w_idx_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      bready  <= bready_d;
      addr_ok <= addr_ok_d;
      data_ok <= data_ok_d;
      done    <= done_d;
`ifdef DCACHE_AXI_RESP_CHK_EN
      bus_err <= bus_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Randomized scoreboard bench for dcache_axi_bridge with a behavioural AXI slave.
module tb_dcache_axi_bridge;

  localparam int          LW         = 8;
  localparam int          IW         = $clog2(LW);
  localparam logic [31:0] LINE_BYTES = 32'(LW * 4);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req = 1'b0, wr = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata;
  logic          addr_ok, data_ok, done;
  logic [31:0]   rdata;
  logic [IW-1:0] w_idx;
  logic [31:0]   araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst;
  logic          arvalid, awvalid, rready, bready, wvalid, wlast;
  logic          arready = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0]   rdata_axi = '0;
  logic          rlast = 1'b0, rvalid = 1'b0;
  logic [31:0]   wdata_axi;
  logic [3:0]    wstrb;
`ifdef DCACHE_AXI_RESP_CHK_EN
  logic [1:0]    rresp = 2'b00, bresp = 2'b00;
  logic          bus_err;
`endif

  dcache_axi_bridge #(.LINE_WORDS(LW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .w_idx(w_idx), .done(done),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata_axi(rdata_axi), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid),
`ifdef DCACHE_AXI_RESP_CHK_EN
    .rresp(rresp), .bresp(bresp), .bus_err(bus_err),
`endif
    .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_wr; logic [31:0] addr; } areq_t;
  typedef struct { logic is_wr; logic [31:0] data; logic last; } beat_t;

  areq_t       exp_addr_q[$];
  beat_t       exp_beat_q[$];
  logic [32:0] exp_w_q[$];     // {last, data}
  logic [31:0] r_word_q[$];
  int          r_len_q[$];
  logic [31:0] wline [LW];

  int n_checks = 0, n_fail = 0;
  int n_rd_exp = 0, n_wr_exp = 0, n_done_exp = 0;
  int n_ar_hs = 0, n_aw_hs = 0, n_done = 0;
  int cyc = 0;
  bit w_toggle = 1'b0;

  always_comb wdata = wline[w_idx];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural AXI slave: random handshake timing, drives one cycle after each edge.
  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, w_last_hs, b_hs, w_active;
    int r_left, b_wait;
    r_left = 0; b_wait = -1; w_active = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs     = arvalid && arready;
      r_hs      = rvalid && rready;
      aw_hs     = awvalid && awready;
      w_hs      = wvalid && wready;
      w_last_hs = w_hs && wlast;
      b_hs      = bvalid && bready;
      @(posedge clk); #1;
      if (!resetn) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; awready = 1'b0;
        wready = 1'b0; bvalid = 1'b0; r_left = 0; w_active = 1'b0; b_wait = -1;
      end else begin
        if (ar_hs) r_left = (r_len_q.size() != 0) ? r_len_q.pop_front() : 0;
        arready = arvalid && ($urandom_range(0, 2) == 0);
        if (r_hs) r_left--;
        if (!(rvalid && !r_hs)) begin
          if (r_left > 0 && r_word_q.size() != 0 && $urandom_range(0, 3) != 0) begin
            rvalid = 1'b1; rdata_axi = r_word_q.pop_front(); rlast = (r_left == 1);
          end else begin
            rvalid = 1'b0; rlast = 1'b0;
          end
        end
        if (aw_hs) w_active = 1'b1;
        awready = awvalid && ($urandom_range(0, 2) == 0);
        if (w_last_hs) begin
          w_active = 1'b0;
          b_wait   = $urandom_range(0, 3);
        end
        if (w_active) wready = w_toggle ? !wready : 1'($urandom_range(0, 1));
        else          wready = 1'b0;
        if (b_hs) bvalid = 1'b0;
        else if (b_wait == 0) begin bvalid = 1'b1; b_wait = -1; end
        else if (b_wait > 0) b_wait--;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pulse or a handshake.
  initial begin : monitor
    logic [32:0] held_w, ew;
    bit          w_hold, b_fire_d;
    areq_t       ea;
    beat_t       eb;
    w_hold = 1'b0; b_fire_d = 1'b0; held_w = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        w_hold = 1'b0; b_fire_d = 1'b0;
      end else begin
        if (b_fire_d) check("done_after_b", 64'(done), 64'd1);
        if (w_hold) check("w_stable_stalled", 64'({wvalid, wlast, wdata_axi}), 64'({1'b1, held_w}));
        if (addr_ok) begin
          check("addr_ok_expected", 64'(exp_addr_q.size() != 0), 64'd1);
          check("addr_ok_before_data_ok", 64'(data_ok), 64'd0);
          if (exp_addr_q.size() != 0) begin
            ea = exp_addr_q.pop_front();
            if (ea.is_wr) check("awaddr", 64'({awvalid, arvalid, awaddr}), 64'({2'b10, ea.addr}));
            else          check("araddr", 64'({arvalid, awvalid, araddr}), 64'({2'b10, ea.addr}));
          end
        end
        if (data_ok) begin
          check("data_ok_expected", 64'(exp_beat_q.size() != 0), 64'd1);
          if (exp_beat_q.size() != 0) begin
            eb = exp_beat_q.pop_front();
            if (eb.is_wr) check("w_data_ok_no_done", 64'(done), 64'd0);
            else          check("rdata_done", 64'({done, rdata}), 64'({eb.last, eb.data}));
          end
        end
        if (done) n_done++;
        if (arvalid && arready) begin
          n_ar_hs++;
          check("ar_attrs", 64'({arlen, arsize, arburst}), 64'({8'(LW - 1), 3'b010, 2'b01}));
        end
        if (awvalid && awready) begin
          n_aw_hs++;
          check("aw_attrs", 64'({awlen, awsize, awburst}), 64'({8'(LW - 1), 3'b010, 2'b01}));
        end
        if (wvalid && wready) begin
          check("w_beat_expected", 64'(exp_w_q.size() != 0), 64'd1);
          if (exp_w_q.size() != 0) begin
            ew = exp_w_q.pop_front();
            check("w_beat", 64'({wstrb, wlast, wdata_axi}), 64'({4'hF, ew}));
          end
        end
        w_hold   = wvalid && !wready;
        held_w   = {wlast, wdata_axi};
        b_fire_d = bvalid && bready;
      end
    end
  end

  // Reference model: the line base is the address rounded down to a line boundary.
  task automatic prep(input bit is_wr, input logic [31:0] a, input int nbeats,
                      input logic [31:0] dbase);
    logic [31:0] w;
    exp_addr_q.push_back('{is_wr, a - (a % LINE_BYTES)});
    n_done_exp++;
    if (is_wr) begin
      n_wr_exp++;
      for (int i = 0; i < LW; i++) begin
        w = (dbase != 0) ? dbase + 32'(i) : $urandom;
        wline[i] = w;
        exp_w_q.push_back({(i == LW - 1), w});
        exp_beat_q.push_back('{1'b1, 32'h0, 1'b0});
      end
    end else begin
      n_rd_exp++;
      r_len_q.push_back(nbeats);
      for (int i = 0; i < nbeats; i++) begin
        w = (dbase != 0) ? dbase + 32'(i) : $urandom;
        r_word_q.push_back(w);
        exp_beat_q.push_back('{1'b0, w, (i == nbeats - 1)});
      end
    end
  endtask

  task automatic wait_addr_ok();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = addr_ok; end
    check("addr_ok_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = done; end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic run_txn(input bit is_wr, input logic [31:0] a, input int nbeats,
                         input logic [31:0] dbase);
    prep(is_wr, a, nbeats, dbase);
    @(posedge clk); #1;
    req = 1'b1; wr = is_wr; addr = a;
    wait_addr_ok();
    @(posedge clk); #1;
    // After acceptance req and wr are don't-care; scramble them.
    req = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); addr = $urandom;
    wait_done();
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t_done;
    bit seen;
    for (int i = 0; i < LW; i++) wline[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok,
                                done, w_idx, rdata}), 64'd0);
    check("const_outputs", 64'({arlen, arsize, arburst, awlen, awsize, awburst, wstrb}),
          64'({8'(LW - 1), 3'b010, 2'b01, 8'(LW - 1), 3'b010, 2'b01, 4'hF}));
    resetn = 1'b1;

    run_txn(1'b0, 32'h1FC0_0014, LW, 32'hA0);
    w_toggle = 1'b1;
    run_txn(1'b1, 32'h1FC0_0123, LW, 32'hB0);
    w_toggle = 1'b0;

    // Refill then writeback with req held high across done.
    prep(1'b0, 32'h0000_4444, LW, 32'h0);
    prep(1'b1, 32'h0000_8888, LW, 32'h0);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h0000_4444;
    wait_addr_ok();
    wait_done();
    t_done = cyc;
    @(posedge clk); #1;
    wr = 1'b1; addr = 32'h0000_8888;
    wait_addr_ok();
    check("b2b_addr_ok_gap", 64'(cyc - t_done), 64'd2);
    @(posedge clk); #1;
    req = 1'b0;
    wait_done();

    for (int n = 0; n < 12; n++) run_txn(1'($urandom_range(0, 1)), $urandom, LW, 32'h0);

`ifdef DCACHE_AXI_RESP_CHK_EN
    check("bus_err_clean", 64'(bus_err), 64'd0);
    run_txn(1'b0, 32'h2000_0040, 5, 32'h0);
    check("bus_err_early_rlast", 64'(bus_err), 64'd1);
    run_txn(1'b0, 32'h2000_0080, LW, 32'h0);
    check("bus_err_sticky", 64'(bus_err), 64'd1);
`endif

    run_txn(1'b0, 32'h3000_0004, 1, 32'h0);        // rlast on the very first beat
    run_txn(1'b0, 32'h3000_1000, LW + 2, 32'h0);   // slave overruns; counter wraps

    // Asynchronous reset in the middle of write beat 3.
    prep(1'b1, 32'h4000_0000, LW, 32'h0);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 32'h4000_0000;
    wait_addr_ok();
    @(posedge clk); #1;
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = (w_idx == 3) && wvalid; end
    check("reached_w_beat3", 64'(seen), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", 64'({arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok,
                                      done, w_idx, rdata}), 64'd0);
    exp_addr_q.delete(); exp_beat_q.delete(); exp_w_q.delete();
    r_word_q.delete(); r_len_q.delete();
    n_done_exp--;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_state", 64'(dut.state), 64'(dcache_pkg::IDLE));
    check("post_reset_w_idx", 64'(w_idx), 64'd0);
`ifdef DCACHE_AXI_RESP_CHK_EN
    check("bus_err_cleared_by_reset", 64'(bus_err), 64'd0);
`endif
    run_txn(1'b0, 32'h5000_0010, LW, 32'h0);
    run_txn(1'b1, 32'h5000_0020, LW, 32'h0);

    repeat (5) @(negedge clk);
    check("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
    check("beat_q_drained", 64'(exp_beat_q.size()), 64'd0);
    check("w_q_drained", 64'(exp_w_q.size()), 64'd0);
    check("ar_handshakes", 64'(n_ar_hs), 64'(n_rd_exp));
    check("aw_handshakes", 64'(n_aw_hs), 64'(n_wr_exp));
    check("done_count", 64'(n_done), 64'(n_done_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
- Sits directly downstream of the dCache controller.
- Converts its line-refill and dirty-line-writeback requests into single AXI4 INCR bursts of LINE_WORDS x 32-bit beats.
- Returns per-beat completion (data_ok) and read data to the controller; on write, pulls line words from the cache via a beat index.
- One outstanding transaction at a time; the cache is the only master behind it.

Parameters:
- LINE_WORDS, 8, words per cache line (2**(DCACHE_B-2)); power of two, 2..16.
- IDX_W, $clog2(LINE_WORDS), beat-index width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req  in  1  cache transaction request, level
- wr  in  1  1 = writeback, 0 = refill; sampled with req
- addr  in  32  line base address; low IDX_W+2 bits forced to 0 internally
- wdata  in  32  line word at w_idx, combinational from cache
- addr_ok  out  1  1-cycle pulse: request accepted
- data_ok  out  1  1-cycle pulse per completed beat
- rdata  out  32  refill word, valid with data_ok
- w_idx  out  IDX_W  current write-beat index
- done  out  1  1-cycle pulse: transaction fully complete
- araddr/arlen/arsize/arburst/arvalid  out  32/8/3/2/1  AXI AR
- arready  in  1  AXI AR
- rdata_axi/rlast/rvalid  in  32/1/1  AXI R
- rready  out  1  AXI R
- awaddr/awlen/awsize/awburst/awvalid  out  32/8/3/2/1  AXI AW
- awready  in  1  AXI AW
- wdata_axi/wstrb/wlast/wvalid  out  32/4/1/1  AXI W
- wready  in  1  AXI W
- bvalid  in  1  AXI B
- bready  out  1  AXI B

Behaviour:
- Reset (resetn low, asynchronous):
  - State IDLE.
  - All valid/ready, addr_ok, data_ok, done outputs 0; rdata 0; w_idx 0.
  - A reset mid-burst abandons the burst; the interconnect shares resetn.
- Constant outputs: arlen = awlen = LINE_WORDS-1; arsize = awsize = 3'b010; arburst = awburst = 2'b01; wstrb = 4'hF.
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - On req: latch aligned addr into araddr/awaddr; pulse addr_ok next cycle.
  - wr=0: arvalid<=1, go to AR.
  - wr=1: awvalid<=1, w_idx<=0, go to AW.
  - req is ignored in every other state.
- AR:
  - Hold arvalid and araddr stable until arready.
  - On arvalid&arready: arvalid<=0, rready<=1, go to R.
- R:
  - Each rvalid&rready: register rdata_axi into rdata and pulse data_ok next cycle (latency 1); increment beat counter.
  - rlast beat: rready<=0, done pulses with that beat's data_ok, go to IDLE.
  - Burst is terminated by rlast only, never by the counter.
  - If the counter wraps past LINE_WORDS-1 without rlast, it wraps to 0 and the bridge stays in R.
- AW:
  - Hold awvalid until awready.
  - On handshake: awvalid<=0, wvalid<=1, go to W.
- W:
  - wdata_axi = wdata (combinational); wlast = (w_idx == LINE_WORDS-1).
  - Cache must hold wdata stable for a fixed w_idx.
  - Each wvalid&wready: w_idx++ and data_ok pulse next cycle.
  - Last beat: wvalid<=0, bready<=1, go to B.
  - wready low: wvalid, wdata_axi and wlast stay stable.
- B: on bvalid: bready<=0, done pulse, go to IDLE.
- Back-to-back: a new request is accepted in IDLE the cycle after done; minimum gap is one cycle.
- Simultaneous rvalid and rlast on the first beat (LINE_WORDS=1 style slave misbehaviour): treated as the final beat; exactly one data_ok and one done.
- addr_ok always precedes the first data_ok by at least one cycle.

Optional Feature:
- Macro: DCACHE_AXI_RESP_CHK_EN
- Defined:
  - Adds inputs rresp[1:0] and bresp[1:0], and sticky output bus_err.
  - bus_err is set when rresp or bresp is non-OKAY on a handshake, or when rlast arrives at a beat count other than LINE_WORDS-1.
  - Cleared only by reset.
- Undefined: these ports and bus_err do not exist; responses are ignored.

Decomposition:
- Shared package dcache_pkg holds:
  - bridge_state_t enum (IDLE, AR, R, AW, W, B).
  - Constants AXI_BURST_INCR = 2'b01, AXI_SIZE_4B = 3'b010, AXI_RESP_OKAY = 2'b00.
  - DCACHE_LINE_WORDS derived from DCACHE_B.
- Single module, no sub-module; the beat counter and FSM stay inline.

Test Plan:
- Refill, LINE_WORDS=8, addr=0x1FC0_0014, slave arready after 2 cycles, R beats 0xA0..0xA7 every cycle -> araddr=0x1FC0_0000, arlen=7; 8 data_ok pulses with rdata 0xA0..0xA7 in order; done coincides with 8th data_ok.
- Writeback, wdata = 0xB0+w_idx, wready toggling 1/0 -> 8 W beats 0xB0..0xB7; wlast only on 0xB7; wdata_axi stable while wready=0; done one cycle after bvalid.
- Refill then immediate writeback: req held high with wr changing after done -> second addr_ok exactly 2 cycles after done, AW issued, no AR reissued.
- Reset asserted during W beat 3 -> all valids, readies and pulses 0 immediately (asynchronous); after release, state IDLE and w_idx 0.
- With DCACHE_AXI_RESP_CHK_EN: rlast on beat 5 of 8 -> done after beat 5, bus_err=1 and stays 1 across a following clean refill.
